interrupt_sequencer: RTL and testbench

- Multi-cycle sequencer ahead of the fetch stage of the 5-stage pipeline.
- Converts the external interrupt line into a hardware interrupt-entry sequence: drain pipeline, push PC high, push PC low, push flags, load vector.
- Sequences the reverse for RTI: pop flags, pop PC low, pop PC high, reload PC and flags.
- Drives fetch stall, PC load and flag restore; pushes and pops go through the memory stage.

---
 rtl/interrupt_sequencer_pkg.sv | 29 ++
 rtl/interrupt_sequencer_int_edge_detect.sv | 31 +++
 rtl/interrupt_sequencer.sv | 151 +++++++++++++++
 tb/tb_interrupt_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and widths for the interrupt entry / RTI sequencer and the
// memory-stage interface it pushes and pops through.
package interrupt_sequencer_pkg;

  localparam int unsigned WORD_W     = 16;
  localparam int unsigned PC_WIDTH   = 2 * WORD_W;
  localparam int unsigned FLAG_WIDTH = 3;  // Z, N, C

  localparam logic [PC_WIDTH-1:0] DEFAULT_INT_VECTOR = 32'h0000_0002;

  // Pipeline control bundle widths seen by the memory-stage interface.
  localparam int unsigned EX_CTRL_W  = 13;
  localparam int unsigned MEM_CTRL_W = 7;
  localparam int unsigned WB_CTRL_W  = 6;

  typedef enum logic [3:0] {
    IDLE,
    DRAIN,
    PUSH_PCH,
    PUSH_PCL,
    PUSH_FLG,
    INT_LOAD,
    POP_FLG,
    POP_PCL,
    POP_PCH,
    RTI_LOAD
  } seq_state_t;

endpackage

// File: rtl/interrupt_sequencer_int_edge_detect.sv
// Rising-edge detector on the external interrupt line with a one-deep
// pending latch; a new edge wins over a same-cycle clear.
module int_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  input  logic clr,
  output logic pending
);

  logic level_q;
  logic rise;

  assign rise = level & ~level_q;

  // level_q resets high so a line already asserted across reset release
  // needs a fresh 0->1 transition before it counts as a request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q <= 1'b1;
      pending <= 1'b0;
    end else begin
      level_q <= level;
      if (rise)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Hardware interrupt entry (drain, push PC/flags, load vector) and RTI
// (pop flags/PC, reload) sequencer sitting ahead of the fetch stage.
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int unsigned       W            = WORD_W,
  parameter int unsigned       PC_W         = 2 * W,
  parameter int unsigned       FLAG_W       = FLAG_WIDTH,
  parameter int unsigned       DRAIN_CYCLES = 3,
  parameter logic [PC_W-1:0]   INT_VECTOR   = DEFAULT_INT_VECTOR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt,
  input  logic              rti_req,
  input  logic [PC_W-1:0]   ret_pc,
  input  logic [FLAG_W-1:0] flags_in,
  output logic              push_valid,
  output logic [W-1:0]      push_data,
  input  logic              push_ready,
  output logic              pop_req,
  input  logic              pop_valid,
  input  logic [W-1:0]      pop_data,
  output logic              stall,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_target,
  output logic              flags_load,
  output logic [FLAG_W-1:0] flags_out,
  output logic              busy
);

  seq_state_t        state, next_state;
  logic [3:0]        drain_cnt;
  logic [PC_W-1:0]   pc_q;    // return PC on entry, rebuilt PC on RTI
  logic [FLAG_W-1:0] flg_q;   // flags on entry, restored flags on RTI
  logic              pending;
  logic              clr_pending;

  int_edge_detect u_edge (
    .clk     (clk),
    .rst     (rst),
    .level   (interrupt),
    .clr     (clr_pending),
    .pending (pending)
  );

  // NOTE: every register, datapath latches included, takes a defined reset
  // value so an aborted frame never leaks stale PC or flags into a later one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      pc_q      <= '0;
      flg_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // same pre-edge values regardless of statement order.
      state <= next_state;
      case (state)
        IDLE:
          if (clr_pending) drain_cnt <= 4'(DRAIN_CYCLES - 1);
        DRAIN:
          if (drain_cnt == '0) begin
            pc_q  <= ret_pc;
            flg_q <= flags_in;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        POP_FLG:
          if (pop_valid) flg_q <= pop_data[FLAG_W-1:0];
        POP_PCL:
          if (pop_valid) pc_q[W-1:0] <= pop_data;
        POP_PCH:
          if (pop_valid) pc_q[PC_W-1:W] <= pop_data;
        default: ;
      endcase
    end
  end

  // Outputs decode the registered state and latches only; push_ready and
  // pop_valid steer next_state alone.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves an output
    // unassigned and infers a latch.
    next_state  = state;
    clr_pending = 1'b0;
    push_valid  = 1'b0;
    push_data   = '0;
    pop_req     = 1'b0;
    pc_load     = 1'b0;
    pc_target   = '0;
    flags_load  = 1'b0;
    flags_out   = '0;
    case (state)
      IDLE: begin
        if (rti_req) begin
          next_state = POP_FLG;
        end else if (pending) begin
          clr_pending = 1'b1;
          next_state  = DRAIN;
        end
      end
      DRAIN:
        if (drain_cnt == '0) next_state = PUSH_PCH;
      PUSH_PCH: begin
        push_valid = 1'b1;
        push_data  = pc_q[PC_W-1:W];
        if (push_ready) next_state = PUSH_PCL;
      end
      PUSH_PCL: begin
        push_valid = 1'b1;
        push_data  = pc_q[W-1:0];
        if (push_ready) next_state = PUSH_FLG;
      end
      PUSH_FLG: begin
        push_valid = 1'b1;
        push_data  = {{(W-FLAG_W){1'b0}}, flg_q};
        if (push_ready) next_state = INT_LOAD;
      end
      INT_LOAD: begin
        pc_load    = 1'b1;
        pc_target  = INT_VECTOR;
        next_state = IDLE;
      end
      POP_FLG: begin
        pop_req = 1'b1;
        if (pop_valid) next_state = POP_PCL;
      end
      POP_PCL: begin
        pop_req = 1'b1;
        if (pop_valid) next_state = POP_PCH;
      end
      POP_PCH: begin
        pop_req = 1'b1;
        if (pop_valid) next_state = RTI_LOAD;
      end
      RTI_LOAD: begin
        pc_load    = 1'b1;
        pc_target  = pc_q;
        flags_load = 1'b1;
        flags_out  = flg_q;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy  = (state != IDLE);
  assign stall = busy;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: cycle tables for interrupt entry
// and backpressure, hand-written sequences for RTI, nesting and reset.
module tb_interrupt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        interrupt;
  logic        rti_req;
  logic [31:0] ret_pc;
  logic [2:0]  flags_in;
  logic        push_valid;
  logic [15:0] push_data;
  logic        push_ready;
  logic        pop_req;
  logic        pop_valid;
  logic [15:0] pop_data;
  logic        stall;
  logic        pc_load;
  logic [31:0] pc_target;
  logic        flags_load;
  logic [2:0]  flags_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  interrupt_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .interrupt  (interrupt),
    .rti_req    (rti_req),
    .ret_pc     (ret_pc),
    .flags_in   (flags_in),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_req    (pop_req),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .stall      (stall),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .flags_load (flags_load),
    .flags_out  (flags_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // One row: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        irq;
    logic        rdy;
    logic        busy;
    logic        pv;
    logic [15:0] pd;
    logic        pl;
    logic [31:0] pt;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic add(input logic irq, input logic rdy, input logic b, input logic pv,
                     input logic [15:0] pd, input logic pl, input logic [31:0] pt);
    vq.push_back('{irq, rdy, b, pv, pd, pl, pt});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " stall"}, 32'(stall), 0);
    check({tag, " push_valid"}, 32'(push_valid), 0);
    check({tag, " push_data"}, 32'(push_data), 0);
    check({tag, " pop_req"}, 32'(pop_req), 0);
    check({tag, " pc_load"}, 32'(pc_load), 0);
    check({tag, " pc_target"}, pc_target, 0);
    check({tag, " flags_load"}, 32'(flags_load), 0);
    check({tag, " flags_out"}, 32'(flags_out), 0);
  endtask

  // Waits for pop_req, returns the word two cycles later.
  task automatic pop_word(input logic [15:0] data);
    int n = 0;
    while (!pop_req && n < 10) begin
      tick();
      n++;
    end
    check("pop_req seen", 32'(pop_req), 1);
    repeat (2) begin
      check("pop_req held", 32'(pop_req), 1);
      tick();
    end
    pop_valid = 1'b1;
    pop_data  = data;
    tick();
    pop_valid = 1'b0;
    pop_data  = 16'hdead;
  endtask

  task automatic count_activity(input int cycles, output int loads, output int pops);
    loads = 0;
    pops  = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (pc_load) loads++;
      if (pop_req) pops++;
    end
  endtask

  initial begin
    int loads, pops, n;
    logic stayed_idle;

    rst = 1'b0; interrupt = 1'b1; rti_req = 1'b0;
    ret_pc = 32'h0001_0034; flags_in = 3'b101;
    push_ready = 1'b1; pop_valid = 1'b0; pop_data = 16'h0;

    // Reset held with the line high, then release with no fresh edge.
    repeat (3) tick();
    check_idle_outputs("reset");
    rst = 1'b1;
    stayed_idle = 1'b1;
    repeat (5) begin
      tick();
      if (busy) stayed_idle = 1'b0;
    end
    check("no start after release", 32'(stayed_idle), 1);
    interrupt = 1'b0;
    tick();

    // Entry with line held high (single pending), then entry with backpressure.
    add(1,1, 0,0,16'h0000,0,32'h0);
    add(1,1, 1,0,16'h0000,0,32'h0);
    add(1,1, 1,0,16'h0000,0,32'h0);
    add(1,1, 1,0,16'h0000,0,32'h0);
    add(1,1, 1,1,16'h0001,0,32'h0);
    add(1,1, 1,1,16'h0034,0,32'h0);
    add(1,1, 1,1,16'h0005,0,32'h0);
    add(1,1, 1,0,16'h0000,1,32'h0000_0002);
    add(1,1, 0,0,16'h0000,0,32'h0);
    add(1,1, 0,0,16'h0000,0,32'h0);
    add(0,1, 0,0,16'h0000,0,32'h0);
    add(1,1, 0,0,16'h0000,0,32'h0);
    add(1,1, 1,0,16'h0000,0,32'h0);
    add(0,1, 1,0,16'h0000,0,32'h0);
    add(0,1, 1,0,16'h0000,0,32'h0);
    add(0,1, 1,1,16'h0001,0,32'h0);
    add(0,1, 1,1,16'h0034,0,32'h0);
    add(0,0, 1,1,16'h0034,0,32'h0);
    add(0,0, 1,1,16'h0034,0,32'h0);
    add(0,0, 1,1,16'h0034,0,32'h0);
    add(0,0, 1,1,16'h0034,0,32'h0);
    add(0,1, 1,1,16'h0005,0,32'h0);
    add(0,1, 1,0,16'h0000,1,32'h0000_0002);
    add(0,1, 0,0,16'h0000,0,32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      interrupt  = vq[i].irq;
      push_ready = vq[i].rdy;
      tick();
      check({tag, " busy"}, 32'(busy), 32'(vq[i].busy));
      check({tag, " stall"}, 32'(stall), 32'(vq[i].busy));
      check({tag, " push_valid"}, 32'(push_valid), 32'(vq[i].pv));
      check({tag, " push_data"}, 32'(push_data), 32'(vq[i].pd));
      check({tag, " pc_load"}, 32'(pc_load), 32'(vq[i].pl));
      check({tag, " pc_target"}, pc_target, vq[i].pt);
      check({tag, " pop_req"}, 32'(pop_req), 0);
    end
    push_ready = 1'b1;

    // pop_valid in IDLE is ignored.
    pop_valid = 1'b1; pop_data = 16'h1234;
    tick();
    pop_valid = 1'b0;
    tick();
    check("stray pop_valid busy", 32'(busy), 0);

    // RTI with delayed pop responses.
    rti_req = 1'b1;
    tick();
    rti_req = 1'b0;
    check("rti busy", 32'(busy), 1);
    pop_word(16'h0003);
    pop_word(16'h0034);
    pop_word(16'h0001);
    check("rti pc_load", 32'(pc_load), 1);
    check("rti pc_target", pc_target, 32'h0001_0034);
    check("rti flags_load", 32'(flags_load), 1);
    check("rti flags_out", 32'(flags_out), 32'(3'b011));
    tick();
    check("rti pc_load pulse", 32'(pc_load), 0);
    check("rti flags_load pulse", 32'(flags_load), 0);
    check("rti done busy", 32'(busy), 0);

    // rti_req and interrupt edge together: RTI first, then entry.
    rti_req = 1'b1; interrupt = 1'b1;
    tick();
    rti_req = 1'b0;
    check("prio pop_req", 32'(pop_req), 1);
    pop_word(16'h0007);
    pop_word(16'h0100);
    pop_word(16'h00ab);
    check("prio rti pc_target", pc_target, 32'h00ab_0100);
    check("prio rti flags_out", 32'(flags_out), 32'(3'b111));
    tick();
    check("prio idle after rti", 32'(busy), 0);
    tick();
    check("prio entry starts", 32'(busy), 1);
    check("prio entry no pop", 32'(pop_req), 0);

    // While busy: ignored rti_req, two edges -> exactly one further entry.
    rti_req = 1'b1; interrupt = 1'b0;
    tick();
    rti_req = 1'b0; interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    tick();
    interrupt = 1'b1;
    tick();
    count_activity(40, loads, pops);
    check("nest pc_load count", 32'(loads), 2);
    check("nest pop count", 32'(pops), 0);
    check("nest end idle", 32'(busy), 0);

    // Reset in PUSH_PCL with a nested request pending.
    interrupt = 1'b0;
    tick();
    interrupt = 1'b1;
    tick();
    interrupt = 1'b0;
    n = 0;
    while (!busy && n < 10) begin tick(); n++; end
    check("rstmid busy", 32'(busy), 1);
    interrupt = 1'b1;
    n = 0;
    while (!(push_valid && push_data == 16'h0034) && n < 20) begin tick(); n++; end
    check("rstmid reached pcl", 32'(push_data), 32'h0034);
    push_ready = 1'b0;
    tick();
    #1 rst = 1'b0;
    #1;
    check_idle_outputs("rstmid");
    tick();
    rst = 1'b1;
    push_ready = 1'b1;
    stayed_idle = 1'b1;
    repeat (12) begin
      tick();
      if (busy) stayed_idle = 1'b0;
    end
    check("rstmid pending cleared", 32'(stayed_idle), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
